// File: rtl/sump_pkg.sv
// Shared definitions for the SUMP host command path:
// opcodes, framing constants and decoder states.
package sump_pkg;

    localparam logic [7:0] SUMP_RESET      = 8'h00;
    localparam logic [7:0] SUMP_ARM        = 8'h01;
    localparam logic [7:0] SUMP_QUERY_ID   = 8'h02;
    localparam logic [7:0] SUMP_QUERY_META = 8'h04;
    localparam logic [7:0] SUMP_XON        = 8'h11;
    localparam logic [7:0] SUMP_XOFF       = 8'h13;

    localparam int LONG_CMD_BIT    = 7;
    localparam int LONG_DATA_BYTES = 4;

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

endpackage

// File: rtl/sump_cmd_timeout.sv
// Saturating inter-byte idle counter; expired holds once the
// count reaches TIMEOUT and stays there until cleared.
module sump_cmd_timeout #(
    parameter int TIMEOUT = 50000,
    parameter int TO_W    = 17
) (
    input  logic clock,
    input  logic extReset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TO_W-1:0] count;

    assign expired = (count == TO_W'(TIMEOUT));

    always_ff @(posedge clock or posedge extReset) begin
        if (extReset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sump_cmd_decoder.sv
// SUMP command assembler: frames short/long commands from the
// receiver byte stream and issues one registered strobe each.
module sump_cmd_decoder
    import sump_pkg::*;
#(
    parameter int TIMEOUT = 50000,
    parameter int TO_W    = 17
) (
    input  logic        clock,
    input  logic        extReset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    input  logic        meta_ack,
    output logic        cmd_strobe,
    output logic [7:0]  opcode,
    output logic [31:0] cmd_data,
    output logic        soft_reset,
    output logic        arm,
    output logic        query_id,
    output logic        query_metadata,
    output logic        cmd_abort
);

    localparam logic [1:0] LAST_BYTE = 2'(LONG_DATA_BYTES - 1);

    state_t      state;
    logic [7:0]  op_latched;
    logic [1:0]  byte_cnt;
    logic [23:0] data_buf;
    logic        expired;
    logic        collecting;

    assign collecting = (state == COLLECT);

    sump_cmd_timeout #(
        .TIMEOUT(TIMEOUT),
        .TO_W   (TO_W)
    ) u_timeout (
        .clock   (clock),
        .extReset(extReset),
        .clear   (!collecting || rx_valid),
        .enable  (collecting),
        .expired (expired)
    );

    always_ff @(posedge clock or posedge extReset) begin
        if (extReset) begin
            state          <= IDLE;
            op_latched     <= '0;
            byte_cnt       <= '0;
            data_buf       <= '0;
            cmd_strobe     <= 1'b0;
            opcode         <= '0;
            cmd_data       <= '0;
            soft_reset     <= 1'b0;
            arm            <= 1'b0;
            query_id       <= 1'b0;
            query_metadata <= 1'b0;
            cmd_abort      <= 1'b0;
        end else begin
            cmd_strobe <= 1'b0;
            soft_reset <= 1'b0;
            arm        <= 1'b0;
            query_id   <= 1'b0;
            cmd_abort  <= 1'b0;
            if (meta_ack) begin
                query_metadata <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (rx_valid && !rx_byte[LONG_CMD_BIT]) begin
                        cmd_strobe <= 1'b1;
                        opcode     <= rx_byte;
                        cmd_data   <= '0;
                        soft_reset <= (rx_byte == SUMP_RESET);
                        arm        <= (rx_byte == SUMP_ARM);
                        query_id   <= (rx_byte == SUMP_QUERY_ID);
                        // A new request outranks a simultaneous ack.
                        if (rx_byte == SUMP_QUERY_META) begin
                            query_metadata <= 1'b1;
                        end
                    end else if (rx_valid) begin
                        op_latched <= rx_byte;
                        byte_cnt   <= '0;
                        state      <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (rx_valid && byte_cnt == LAST_BYTE) begin
                        cmd_strobe <= 1'b1;
                        opcode     <= op_latched;
                        cmd_data   <= {rx_byte, data_buf};
                        state      <= IDLE;
                    end else if (rx_valid) begin
                        // Shift in from the top so byte 0 ends up lowest.
                        data_buf <= {rx_byte, data_buf[23:8]};
                        byte_cnt <= byte_cnt + 1'b1;
                    end else if (expired) begin
                        cmd_abort <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
